rr_arbiter_6: RTL and testbench
===============================

Name: rr_arbiter_6

Overview:
- Six-requester round-robin arbiter that shares one pipeline resource, such as the single memory port or the write-back bus, between pipeline stages.
- Grants exactly one requester at a time and holds the grant until the owner signals completion.
- Request inactivity is a 6-input NOR over polarity-corrected requests; `idle` is exactly this NOR.
- Sits between the stage request lines and the shared-resource mux select.

Parameters:
- BubblesMask, default 6'b000000: per-bit request polarity. Bit i = 1 means req[i] is active-low and is inverted before arbitration.
- MAX_HOLD, default 16: maximum cycles one grant may be held before forced release. Used only with ARB6_TIMEOUT_EN. Legal range 2..255.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  6  raw request lines; polarity is set by BubblesMask.
- done  input  1  current owner finished; sampled only while busy.
- grant  output  6  one-hot grant, registered.
- grant_valid  output  1  high when grant is non-zero.
- grant_id  output  3  binary index of the granted requester, 0..5; 0 when not granted.
- idle  output  1  combinational NOR of the 6 corrected requests.
- timeout  output  1  one-cycle pulse on forced release; held 0 when the macro is off.

Behaviour:
- Interface: one clock, `clock`. Reset is `reset`, synchronous and active-high, sampled on the rising edge of `clock`.
- Request correction: real_req[i] = req[i] XOR BubblesMask[i]. All arbitration uses real_req.
- Reset values: grant = 0, grant_valid = 0, grant_id = 0, timeout = 0, state = IDLE, last_ptr = 5. With last_ptr = 5, the first search starts at index 0.
- State IDLE:
  - If any real_req is set, pick the first set bit searching upward from (last_ptr + 1) mod 6, wrapping past 5 to 0.
  - Register the pick into grant, grant_id and last_ptr. Go to BUSY.
  - Latency from request to grant is 1 cycle.
- State BUSY:
  - Grant is held regardless of the owner's real_req. A dropped request does not release the grant; only done or a timeout does.
- done = 1 in BUSY, with other real_req pending:
  - Re-arbitrate in the same edge, excluding nothing. The search starts at last_ptr + 1.
  - The next grant appears on the following cycle with no dead cycle; this is back-to-back.
  - The new owner may be the same index only if it is the sole real_req.
- done = 1 in BUSY, with no real_req pending: grant goes to 0 next cycle and state returns to IDLE.
- done while in IDLE is ignored.
- Fairness: a continuously requesting index waits at most 5 grants.
- Simultaneous requests are resolved only by rotating priority; there is no fixed priority.
- Reset during BUSY: grant drops on the next edge and last_ptr returns to 5.
- grant_valid = |grant at all times.

Optional Feature:
- Macro ARB6_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on every new grant and increments each BUSY cycle.
  - When the counter reaches MAX_HOLD - 1 without done, the grant is forcibly released exactly as if done had been asserted.
  - timeout pulses high for 1 cycle, aligned with the cycle in which the new grant or zero grant is visible.
  - If done and the timeout condition fall in the same cycle, done wins and timeout stays 0.
- Not defined: no counter is built, timeout is tied to 0, and a grant is held indefinitely until done.

Test Plan:
- Reset with req = 6'h3F -> grant = 0 during reset. First grant one cycle after reset deasserts: grant = 6'b000001, grant_id = 0.
- req = 6'b100100, pulse done each grant -> grants follow index order 2, 5, 2, 5. grant_valid stays 1 with no gap cycle.
- All requests held high, done every 3 cycles -> grant_id sequence is 0, 1, 2, 3, 4, 5, 0. Each hold lasts 3 cycles.
- Owner drops its request mid-grant with no done -> grant is held. After done with req = 0 -> grant = 0 next cycle and idle = 1.
- BubblesMask = 6'b000011, req = 6'b000011 -> idle = 1 and no grant. Driving req[0] = 0 grants index 0.
- With ARB6_TIMEOUT_EN and MAX_HOLD = 4, owner never asserts done -> forced release after 4 BUSY cycles, timeout is a 1-cycle pulse and the next requester is granted. Without the macro, the same stimulus holds the grant for 100 cycles and timeout stays 0.

Source files
------------

// File: rtl/rr_arbiter_6.sv
// Six-requester round-robin arbiter that holds each grant until the owner signals done.
// Optional forced release after MAX_HOLD cycles is built when ARB6_TIMEOUT_EN is defined.
module rr_arbiter_6 #(
  parameter logic [5:0] BubblesMask = 6'b000000,
  parameter int         MAX_HOLD    = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] req,
  input  logic       done,
  output logic [5:0] grant,
  output logic       grant_valid,
  output logic [2:0] grant_id,
  output logic       idle,
  output logic       timeout,
  output logic       busy
);

  // Handshake: a requester holds its (corrected) req until granted; the owner
  // keeps the resource while grant is set and asserts done for one cycle to
  // hand it back. done is only observed while busy.

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [5:0] real_req;
  logic [2:0] last_ptr;
  logic       pick_found;
  logic [2:0] pick_id;
  logic [3:0] cand;
  logic       forced;
  logic       release_now;

  assign real_req    = req ^ BubblesMask;
  assign idle        = ~|real_req;
  assign grant_valid = |grant;
  assign busy        = (state == BUSY);

  // Rotating search: offsets 1..6 past last_ptr, so last_ptr itself is tried last.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = 3'd0;
    cand       = 4'd0;
    for (int k = 1; k <= 6; k++) begin
      cand = {1'b0, last_ptr} + 4'(k);
      if (cand >= 4'd6) cand = cand - 4'd6;
      if (!pick_found && real_req[cand[2:0]]) begin
        pick_found = 1'b1;
        pick_id    = cand[2:0];
      end
    end
  end

`ifdef ARB6_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;

  // done takes precedence, so a coincident done never raises timeout.
  assign forced = (hold_cnt == HOLD_LAST) && !done;

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      timeout <= (state == BUSY) && forced;
      if (state == IDLE || release_now) hold_cnt <= 8'd0;
      else                              hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  assign forced  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign release_now = done || forced;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= 6'd0;
      grant_id <= 3'd0;
      last_ptr <= 3'd5;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant    <= 6'b000001 << pick_id;
            grant_id <= pick_id;
            last_ptr <= pick_id;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (release_now) begin
            if (pick_found) begin
              grant    <= 6'b000001 << pick_id;
              grant_id <= pick_id;
              last_ptr <= pick_id;
            end else begin
              grant    <= 6'd0;
              grant_id <= 3'd0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_6.sv
// Directed bench for rr_arbiter_6: expected grants are queued as stimulus is
// driven and compared one cycle later; a second instance covers BubblesMask.
module tb_rr_arbiter_6;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] req, req_b;
  logic       done, done_b;
  logic [5:0] grant, grant_b;
  logic       grant_valid, grant_valid_b;
  logic [2:0] grant_id, grant_id_b;
  logic       idle, idle_b;
  logic       timeout, timeout_b;
  logic       busy, busy_b;

  int passed = 0;
  int total  = 0;
  logic [5:0] exp_q[$];

  always #5 clock = ~clock;

  rr_arbiter_6 #(.BubblesMask(6'b000000), .MAX_HOLD(4)) dut (
    .clock(clock), .reset(reset), .req(req), .done(done),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
    .idle(idle), .timeout(timeout), .busy(busy)
  );

  rr_arbiter_6 #(.BubblesMask(6'b000011), .MAX_HOLD(4)) dut_b (
    .clock(clock), .reset(reset), .req(req_b), .done(done_b),
    .grant(grant_b), .grant_valid(grant_valid_b), .grant_id(grant_id_b),
    .idle(idle_b), .timeout(timeout_b), .busy(busy_b)
  );

  function automatic logic [2:0] id_of(input logic [5:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 6; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(input logic [5:0] g);
    exp_q.push_back(g);
  endtask

  task automatic tick_check(input string tag);
    logic [5:0] e;
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      $error("FAIL %s observed=no_entry expected=queued_grant", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".grant"}, 8'(grant), 8'(e));
      chk({tag, ".valid"}, 8'(grant_valid), 8'(|e));
      chk({tag, ".id"}, 8'(grant_id), 8'(id_of(e)));
      chk({tag, ".busy"}, 8'(busy), 8'(|e));
    end
  endtask

  initial begin
    logic [5:0] oh;
    reset = 1'b1; req = 6'h3F; done = 1'b0;
    req_b = 6'b000011; done_b = 1'b0;

    // Reset with every request active
    push(6'd0); tick_check("rst0");
    push(6'd0); tick_check("rst1");
    chk("rst.timeout", 8'(timeout), 8'd0);
    chk("rst.idle", 8'(idle), 8'd0);
    reset = 1'b0;
    push(6'b000001); tick_check("first");
    req = 6'd0; done = 1'b1;
    push(6'd0); tick_check("first_rel");
    chk("first_rel.idle", 8'(idle), 8'd1);
    done = 1'b0;

    // Two requesters, done every grant: 2,5,2,5 back-to-back
    req = 6'b100100;
    push(6'b000100); tick_check("pair0");
    done = 1'b1;
    push(6'b100000); tick_check("pair1");
    push(6'b000100); tick_check("pair2");
    push(6'b100000); tick_check("pair3");
    req = 6'd0;
    push(6'd0); tick_check("pair_rel");
    done = 1'b0;

    // All requesting, each grant held three cycles: 0..5 then 0
    req = 6'h3F;
    for (int g = 0; g < 7; g++) begin
      for (int c = 0; c < 3; c++) begin
        done = (g > 0) && (c == 0);
        oh = 6'b000001;
        oh = oh << (g % 6);
        push(oh);
        tick_check($sformatf("rot%0d_%0d", g, c));
      end
    end
    req = 6'd0; done = 1'b1;
    push(6'd0); tick_check("rot_rel");
    done = 1'b0;

    // Owner drops its request: grant holds until done
    req = 6'b000010;
    push(6'b000010); tick_check("drop_grant");
    chk("drop_grant.idle", 8'(idle), 8'd0);
    req = 6'd0;
    for (int c = 0; c < 3; c++) begin
      push(6'b000010); tick_check($sformatf("drop_hold%0d", c));
      chk("drop_hold.idle", 8'(idle), 8'd1);
    end
    done = 1'b1;
    push(6'd0); tick_check("drop_rel");
    chk("drop_rel.idle", 8'(idle), 8'd1);
    chk("drop_rel.timeout", 8'(timeout), 8'd0);
    done = 1'b0;

    // Owner never signals done
    req = 6'b001001;
    push(6'b001000); tick_check("to_grant");
`ifdef ARB6_TIMEOUT_EN
    for (int c = 0; c < 3; c++) begin
      push(6'b001000); tick_check($sformatf("to_hold%0d", c));
      chk("to_hold.timeout", 8'(timeout), 8'd0);
    end
    push(6'b000001); tick_check("to_release");
    chk("to_release.timeout", 8'(timeout), 8'd1);
    push(6'b000001); tick_check("to_after");
    chk("to_after.timeout", 8'(timeout), 8'd0);
`else
    for (int c = 0; c < 100; c++) begin
      push(6'b001000); tick_check($sformatf("to_hold%0d", c));
      chk("to_hold.timeout", 8'(timeout), 8'd0);
    end
`endif
    req = 6'd0; done = 1'b1;
    push(6'd0); tick_check("to_clear");
    done = 1'b0;

    // Reset while busy restores the pointer
    req = 6'b000100;
    push(6'b000100); tick_check("rb_grant");
    reset = 1'b1;
    push(6'd0); tick_check("rb_reset");
    reset = 1'b0; req = 6'h3F;
    push(6'b000001); tick_check("rb_first");

    // Sole requester re-granted back-to-back, then done in IDLE is ignored
    req = 6'b000001; done = 1'b1;
    push(6'b000001); tick_check("sole_regrant");
    req = 6'd0;
    push(6'd0); tick_check("sole_rel");
    push(6'd0); tick_check("idle_done");
    done = 1'b0;

    // Active-low requesters on bits 0 and 1
    chk("mask.idle", 8'(idle_b), 8'd1);
    chk("mask.grant", 8'(grant_b), 8'd0);
    chk("mask.valid", 8'(grant_valid_b), 8'd0);
    req_b = 6'b000010;
    @(posedge clock);
    #1;
    chk("mask.req0.grant", 8'(grant_b), 8'h01);
    chk("mask.req0.id", 8'(grant_id_b), 8'd0);
    chk("mask.req0.idle", 8'(idle_b), 8'd0);
    chk("mask.timeout", 8'(timeout_b), 8'd0);

    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
